// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between ALU (A) and load (M) writebacks.
// M has fixed priority; a saturating starvation counter forces an A grant after STARVE_LIMIT denials.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_reg_name,
  input  logic [31:0] a_reg_val,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_reg_name,
  input  logic [31:0] m_reg_val,
  output logic        w_enable,
  output logic [4:0]  w_reg_name,
  output logic [31:0] w_reg_val,
  output logic [31:0] busy,
  output logic        w_src
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             w_enable_q, w_enable_d;
  logic [4:0]       w_reg_name_q, w_reg_name_d;
  logic [31:0]      w_reg_val_q, w_reg_val_d;
  logic             w_src_q, w_src_d;
  logic             grant_a, grant_m;

  // Grants depend only on current requests and the counter, never on prior ready.
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (rst_n && !flush) begin
      if (a_valid && (!m_valid || starve_cnt_q >= LIMIT)) begin
        grant_a = 1'b1;
      end else if (m_valid) begin
        grant_m = 1'b1;
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    w_enable_d   = 1'b0;
    w_reg_name_d = w_reg_name_q;
    w_reg_val_d  = w_reg_val_q;
    w_src_d      = w_src_q;

    if (!flush) begin
      if (!a_valid || grant_a) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q < LIMIT) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end

    // x0 requests are consumed but never reach the regfile.
    if (grant_a && a_reg_name != 5'd0) begin
      w_enable_d   = 1'b1;
      w_reg_name_d = a_reg_name;
      w_reg_val_d  = a_reg_val;
      w_src_d      = 1'b0;
    end else if (grant_m && m_reg_name != 5'd0) begin
      w_enable_d   = 1'b1;
      w_reg_name_d = m_reg_name;
      w_reg_val_d  = m_reg_val;
      w_src_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      w_enable_q   <= 1'b0;
      w_reg_name_q <= '0;
      w_reg_val_q  <= '0;
      w_src_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      w_enable_q   <= w_enable_d;
      w_reg_name_q <= w_reg_name_d;
      w_reg_val_q  <= w_reg_val_d;
      w_src_q      <= w_src_d;
    end
  end

  always_comb begin
    busy = '0;
    if (w_enable_q) begin
      busy[w_reg_name_q] = 1'b1;
    end
  end

  assign a_ready    = grant_a;
  assign m_ready    = grant_m;
  assign w_enable   = w_enable_q;
  assign w_reg_name = w_reg_name_q;
  assign w_reg_val  = w_reg_val_q;
  assign w_src      = w_src_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name:
regfile_wb_arbiter

Overview:
- Shares the single regfile write port between two writeback sources: ALU results (A) and load data returning from memory (M).
- Each source uses a valid/ready handshake. The block grants at most one source per cycle and registers the winner into the regfile write-port signals (w_enable, w_reg_name, w_reg_val).
- Sits between the execute/memory stages and regfile.
- Priority rule: M has fixed priority. A has an anti-starvation counter, so it is never blocked forever.

Parameters:
- STARVE_LIMIT, 3: consecutive cycles A may be denied while valid; on the next contended cycle A wins. Range 1..15.
- CNT_W, 4: width of the starvation counter. Must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; blocks grants this cycle and kills the write being issued
- a_valid  in  1  ALU writeback request
- a_ready  out  1  A accepted this cycle (combinational)
- a_reg_name  in  5  A destination register
- a_reg_val  in  32  A result
- m_valid  in  1  load writeback request
- m_ready  out  1  M accepted this cycle (combinational)
- m_reg_name  in  5  M destination register
- m_reg_val  in  32  M load data
- w_enable  out  1  regfile write enable (registered)
- w_reg_name  out  5  regfile write register (registered)
- w_reg_val  out  32  regfile write data (registered)
- busy  out  32  bit r=1 while register r is being written this cycle (w_enable && w_reg_name==r); for hazard/bypass logic
- w_src  out  1  0 = current write came from A, 1 = from M (registered)

Behaviour:
Reset (asynchronous, immediate on rst_n=0; also applies mid-operation):
- w_enable=0, w_reg_name=0, w_reg_val=0, w_src=0, starve_cnt=0.
- a_ready=m_ready=0 while rst_n=0.

Grant logic (combinational, evaluated each cycle):
- flush=1: no grant; a_ready=m_ready=0.
- Only one valid: that source is granted.
- Both valid: A is granted if starve_cnt>=STARVE_LIMIT, otherwise M is granted.
- Neither valid: no grant.
- Ready is asserted only for the granted source. A handshake completes when valid&&ready at a rising edge.
- Requesters hold valid/name/val stable until ready. Ready never depends on the previous cycle's ready, so there is no combinational loop.

Starvation counter (starve_cnt, CNT_W bits):
- Cleared to 0 when A is granted or a_valid=0.
- Increments, saturating at STARVE_LIMIT, when a_valid=1, A is not granted, and flush=0.
- Holds during flush.

Output register (1-cycle latency from handshake to regfile write):
- Grant with name!=0: w_enable<=1, w_reg_name/w_reg_val<=source payload, w_src<=source.
- Grant with name==0 (x0): request consumed (ready=1), w_enable<=0. x0 is never written.
- No grant or flush: w_enable<=0; w_reg_name, w_reg_val and w_src hold their values.

Other rules:
- busy is a combinational one-hot decode of w_reg_name gated by w_enable; all zeros when w_enable=0.
- Same destination from both sources in the same cycle: only the granted one is issued. The loser is written in a later cycle and therefore overwrites. Ordering is the producer's responsibility.
- Back-to-back grants produce consecutive writes with no bubble: one write per cycle maximum.

Test Plan:
1. Reset: assert rst_n=0 while w_enable=1 and starve_cnt=2 -> w_enable=0, w_reg_name=0 and a_ready=m_ready=0 without waiting for a clock edge. After release with no requests, outputs stay 0.
2. Single source: a_valid=1, a_reg_name=5, a_reg_val=42 -> a_ready=1 same cycle. After the next edge: w_enable=1, w_reg_name=5, w_reg_val=0x2a, w_src=0, busy=0x00000020. The cycle after (no request): w_enable=0, busy=0.
3. Contention, STARVE_LIMIT=3: a_valid=m_valid=1 held continuously with distinct regs -> m_ready=1 in cycles 0,1,2 (starve_cnt 1,2,3). In cycle 3 a_ready=1, then the counter returns to 0. Cycle 4 grants M again.
4. x0 drop: m_valid=1, m_reg_name=0, m_reg_val=0xdeadbeef -> m_ready=1. Next cycle w_enable=0 and busy=0.
5. Flush: both valid and flush=1 for one cycle, starve_cnt=1 -> a_ready=m_ready=0, starve_cnt stays 1, w_enable=0 after the edge. The next cycle grants M.
6. Back-to-back: A writes r3=53 then r5=42 on consecutive cycles -> w_enable stays 1 for 2 cycles, with (3,0x35) then (5,0x2a). A subsequent regfile read of r3 returns 0x35 and r5 returns 0x2a.
